// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
//   Shared constants for the real-time-clock time counter.
//   - set_sel_e : encoding of the field selector used in set mode
//   - *_LIMIT   : largest legal value of each time field
//   - *_MODULUS : number of states of each field counter (limit + 1)
// -----------------------------------------------------------------------------
package rtc_pkg;

    // Field selector used while adjusting the time by hand
    typedef enum logic [1:0] {
        SEL_SEC  = 2'b00,
        SEL_MIN  = 2'b01,
        SEL_HR   = 2'b10,
        SEL_NONE = 2'b11
    } set_sel_e;

    localparam int SEC_LIMIT = 59;
    localparam int MIN_LIMIT = 59;
    localparam int HR_LIMIT  = 23;

    localparam int SEC_MODULUS = SEC_LIMIT + 1;
    localparam int MIN_MODULUS = MIN_LIMIT + 1;
    localparam int HR_MODULUS  = HR_LIMIT + 1;

endpackage

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD counter that counts 00 .. MODULUS-1 and wraps to 00.
//   Digits are always legal BCD and never exceed the modulus.
//
//   Ports
//     clk    : system clock, rising edge
//     clear  : synchronous clear to 00, has priority over en
//     en     : advance by one on this edge
//     tens_o : registered tens digit
//     ones_o : registered ones digit
//     carry  : high while en=1 and the counter sits at MODULUS-1, i.e. this
//              edge wraps it to 00; used to chain into the next field
// -----------------------------------------------------------------------------
module bcd_mod_counter #(
    parameter int MODULUS = 60
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       carry
);

    localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       atMax;

    assign atMax = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign carry = en && atMax;

    // Next value: terminal count wraps to 00, a ones digit of 9 rolls into
    // the tens digit, otherwise only the ones digit moves.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (en) begin
            if (atMax) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == 4'd9) begin
                tens_d = tens_q + 4'd1;
                ones_d = 4'd0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Digit registers; clear doubles as the synchronous reset
    always_ff @(posedge clk) begin
        if (clear) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/rtc_time_counter.sv
// -----------------------------------------------------------------------------
// rtc_time_counter
//   24-hour BCD time-of-day counter driven by a prescaled 1 Hz tick, with a
//   set mode for adjusting seconds, minutes and hours by single increments.
//
//   Parameter
//     CLK_FREQ_HZ : input clock frequency, prescaler period (>= 2)
//
//   Ports
//     clk              : system clock, rising edge
//     rst_n            : synchronous active-low reset to 00:00:00
//     run              : 1 = timekeeping advances, 0 = everything holds
//     set_en           : 1 = set mode, normal counting suspended
//     set_sel          : field to adjust (sec / min / hr / none)
//     inc              : one increment of the selected field per high cycle
//     hr_tens..sec_ones: registered BCD digits of the time
//     tick_1hz         : one-cycle pulse after each seconds advance
//     day_wrap         : one-cycle pulse when 00:00:00 first appears by rollover
// -----------------------------------------------------------------------------
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick_1hz,
    output logic       day_wrap
);

    localparam int                    PRESCALE_W   = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(CLK_FREQ_HZ - 1);

    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  tick1hz_q, tick1hz_d;
    logic                  dayWrap_q, dayWrap_d;

    logic tickNow;
    logic secSetInc, minSetInc, hrSetInc;
    logic secEn, minEn, hrEn;
    logic secCarry, minCarry, hrCarry;
    logic counterClear;

    // The tick cycle is the last prescaler state while counting. set_en is
    // part of the term so a set request landing on that same cycle wins.
    assign tickNow = run && !set_en && (prescale_q == PRESCALE_MAX);

    // Prescaler: forced to 0 in set mode so the first tick after leaving set
    // mode is a full period away; frozen while run is low.
    always_comb begin
        prescale_d = prescale_q;
        if (set_en) begin
            prescale_d = '0;
        end else if (run) begin
            if (tickNow) begin
                prescale_d = '0;
            end else begin
                prescale_d = prescale_q + PRESCALE_W'(1);
            end
        end
    end

    // Set-mode decode: route an inc pulse to exactly one field
    always_comb begin
        secSetInc = 1'b0;
        minSetInc = 1'b0;
        hrSetInc  = 1'b0;
        if (set_en && inc) begin
            case (set_sel_e'(set_sel))
                SEL_SEC: secSetInc = 1'b1;
                SEL_MIN: minSetInc = 1'b1;
                SEL_HR:  hrSetInc  = 1'b1;
                default: ;
            endcase
        end
    end

    // Carries only propagate on a tick; set-mode increments wrap in place
    // because tickNow is never true while set_en is high.
    assign secEn = tickNow | secSetInc;
    assign minEn = (tickNow & secCarry) | minSetInc;
    assign hrEn  = (tickNow & minCarry) | hrSetInc;

    assign tick1hz_d = tickNow;
    assign dayWrap_d = tickNow & hrCarry;

    assign counterClear = !rst_n;

    // Prescaler and status pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale_q <= '0;
            tick1hz_q  <= 1'b0;
            dayWrap_q  <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            tick1hz_q  <= tick1hz_d;
            dayWrap_q  <= dayWrap_d;
        end
    end

    bcd_mod_counter #(
        .MODULUS (SEC_MODULUS)
    ) u_seconds (
        .clk    (clk),
        .clear  (counterClear),
        .en     (secEn),
        .tens_o (sec_tens),
        .ones_o (sec_ones),
        .carry  (secCarry)
    );

    bcd_mod_counter #(
        .MODULUS (MIN_MODULUS)
    ) u_minutes (
        .clk    (clk),
        .clear  (counterClear),
        .en     (minEn),
        .tens_o (min_tens),
        .ones_o (min_ones),
        .carry  (minCarry)
    );

    bcd_mod_counter #(
        .MODULUS (HR_MODULUS)
    ) u_hours (
        .clk    (clk),
        .clear  (counterClear),
        .en     (hrEn),
        .tens_o (hr_tens),
        .ones_o (hr_ones),
        .carry  (hrCarry)
    );

    assign tick_1hz = tick1hz_q;
    assign day_wrap = dayWrap_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// -----------------------------------------------------------------------------
// tb_rtc_time_counter
//   Self-checking bench for rtc_time_counter with a 4-cycle prescaler.
//   A reference model keeps the time as a count of seconds since midnight.
// -----------------------------------------------------------------------------
module tb_rtc_time_counter;

    localparam int FREQ = 4;
    localparam int DAY_SECS = 86400;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       set_en;
    logic [1:0] set_sel;
    logic       inc;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       tick_1hz;
    logic       day_wrap;

    int checksTotal  = 0;
    int checksPassed = 0;

    int modelSecs = 0;
    int modelPre  = 0;
    bit modelTick = 1'b0;
    bit modelDw   = 1'b0;

    typedef struct {
        bit       rstN;
        bit       runV;
        bit       setEn;
        bit [1:0] sel;
        bit       incV;
        int       expSecs;
        bit       expTick;
        bit       expDw;
    } vec_t;

    vec_t vecs[13];

    rtc_time_counter #(
        .CLK_FREQ_HZ (FREQ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .set_en   (set_en),
        .set_sel  (set_sel),
        .inc      (inc),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .tick_1hz (tick_1hz),
        .day_wrap (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all outputs against a time given in seconds since midnight
    task automatic checkOutput(input string name, input int expSecs, input bit expTick, input bit expDw);
        int h, m, s;
        logic [25:0] expV, actV;
        h = expSecs / 3600;
        m = (expSecs / 60) % 60;
        s = expSecs % 60;
        expV = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), expTick, expDw};
        actV = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, tick_1hz, day_wrap};
        checksTotal++;
        if (actV === expV) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s at %0t: actual %h%h:%h%h:%h%h tick=%b wrap=%b, required %0d%0d:%0d%0d:%0d%0d tick=%b wrap=%b",
                     name, $time, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, tick_1hz, day_wrap,
                     h / 10, h % 10, m / 10, m % 10, s / 10, s % 10, expTick, expDw);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check after it
    task automatic applyStimulus(input bit rstN, input bit runV, input bit setEn, input bit [1:0] sel, input bit incV);
        int h, m, s;
        rst_n   = rstN;
        run     = runV;
        set_en  = setEn;
        set_sel = sel;
        inc     = incV;
        @(posedge clk);
        h = modelSecs / 3600;
        m = (modelSecs / 60) % 60;
        s = modelSecs % 60;
        modelTick = 1'b0;
        modelDw   = 1'b0;
        if (!rstN) begin
            modelSecs = 0;
            modelPre  = 0;
        end else if (setEn) begin
            modelPre = 0;
            if (incV) begin
                case (sel)
                    2'b00: s = (s + 1) % 60;
                    2'b01: m = (m + 1) % 60;
                    2'b10: h = (h + 1) % 24;
                    default: ;
                endcase
                modelSecs = h * 3600 + m * 60 + s;
            end
        end else if (runV) begin
            if (modelPre == FREQ - 1) begin
                modelPre  = 0;
                modelSecs = (modelSecs + 1) % DAY_SECS;
                modelTick = 1'b1;
                modelDw   = (modelSecs == 0);
            end else begin
                modelPre++;
            end
        end
        #1;
        checkOutput("model", modelSecs, modelTick, modelDw);
    endtask

    task automatic setField(input bit [1:0] sel, input int count);
        for (int i = 0; i < count; i++) applyStimulus(1'b1, 1'b0, 1'b1, sel, 1'b1);
    endtask

    task automatic runCycles(input int count);
        for (int i = 0; i < count; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        run     = 1'b0;
        set_en  = 1'b0;
        set_sel = 2'b11;
        inc     = 1'b0;

        // Reset, first tick, set-mode increment, inc ignored outside set mode
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 3, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 3, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].runV, vecs[i].setEn, vecs[i].sel, vecs[i].incV);
            checkOutput($sformatf("vec%0d", i), vecs[i].expSecs, vecs[i].expTick, vecs[i].expDw);
        end

        // Midnight rollover from 23:59:59
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        setField(2'b10, 23);
        setField(2'b01, 59);
        setField(2'b00, 59);
        checkOutput("set_235959", DAY_SECS - 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            runCycles(1);
            checkOutput("pre_wrap", DAY_SECS - 1, 1'b0, 1'b0);
        end
        runCycles(1);
        checkOutput("day_wrap", 0, 1'b1, 1'b1);
        runCycles(1);
        checkOutput("day_wrap_end", 0, 1'b0, 1'b0);

        // Hours wrap in set mode without touching other fields
        setField(2'b10, 23);
        setField(2'b01, 5);
        setField(2'b00, 7);
        setField(2'b10, 1);
        checkOutput("hr_set_wrap", 5 * 60 + 7, 1'b0, 1'b0);

        // set_en on the would-be tick cycle wins; next tick a full period later
        runCycles(3);
        checkOutput("pre_at_3", 5 * 60 + 7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 1'b0);
        checkOutput("set_beats_tick", 5 * 60 + 7, 1'b0, 1'b0);
        runCycles(3);
        checkOutput("after_set_wait", 5 * 60 + 7, 1'b0, 1'b0);
        runCycles(1);
        checkOutput("after_set_tick", 5 * 60 + 8, 1'b1, 1'b0);

        // Reset mid-count discards the partial prescaler count
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        setField(2'b00, 59);
        runCycles(2);
        checkOutput("at_59_pre2", 59, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        checkOutput("mid_reset", 0, 1'b0, 1'b0);
        runCycles(3);
        checkOutput("post_reset_wait", 0, 1'b0, 1'b0);
        runCycles(1);
        checkOutput("post_reset_tick", 1, 1'b1, 1'b0);

        // Hold at 12:34:56 with run low; stray inc outside set mode ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        setField(2'b10, 12);
        setField(2'b01, 34);
        setField(2'b00, 56);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            checkOutput("hold_run0", 12 * 3600 + 34 * 60 + 56, 1'b0, 1'b0);
        end

        // Randomized traffic against the model, starting near midnight
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        setField(2'b10, 23);
        setField(2'b01, 59);
        setField(2'b00, 50);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 127) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0,
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
